// File: rtl/dcmi_pkg.sv
// Shared definitions for the DCMI-to-memory DMA controller.
// Holds the state encoding and the bus widths.
package dcmi_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FS = 3'd1,
        XFER    = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4,
        HALT    = 3'd5
    } dcmi_state_e;

endpackage

// File: rtl/dcmi_dma_ctrl_if.sv
// Pixel FIFO pop port and memory write port of the DCMI DMA controller.
// The DMA side is the master; the FIFO/memory side is the slave.
interface dcmi_dma_ctrl_if;
    import dcmi_pkg::*;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_rd;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;

    modport master (
        input  fifo_empty, fifo_rdata, mem_gnt,
        output fifo_rd, mem_req, mem_addr, mem_wdata
    );

    modport slave (
        output fifo_empty, fifo_rdata, mem_gnt,
        input  fifo_rd, mem_req, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcmi_dma_ctrl.sv
// Moves camera words from a first-word-fall-through FIFO into a frame buffer,
// one memory write per word, with overflow and frame-sync error reporting.
module dcmi_dma_ctrl
    import dcmi_pkg::*;
(
    input  logic              hclk,
    input  logic              rstn,
    input  logic              capture_en,
    input  logic              snapshot_mode,
    input  logic [ADDR_W-1:0] dcmi_dma_saddr,
    input  logic [ADDR_W-1:0] dcmi_dma_len,
    input  logic              frame_start,
    input  logic              frame_end,
    dcmi_dma_ctrl_if.master   bus,
    output logic              busy,
    output logic [ADDR_W-1:0] words_written,
    output logic              frame_done_pulse,
    output logic              ovf_err_pulse,
    output logic              sync_err_pulse
);

    dcmi_state_e       state, state_nxt;
    logic [ADDR_W-1:0] next_addr, len_q, words_q, mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_req_q, ovf_q, restart_q;
    logic              mem_free, pop, pop_keep, load_frame, restart_set, restart_clr;

    // A restart (sync error) or abort waits for the outstanding write to be granted.
    always_comb begin
        state_nxt   = state;
        load_frame  = 1'b0;
        restart_set = 1'b0;
        restart_clr = 1'b0;
        pop         = 1'b0;
        sync_err_pulse = 1'b0;
        mem_free    = !mem_req_q || bus.mem_gnt;
        case (state)
            IDLE: if (capture_en) state_nxt = WAIT_FS;
            WAIT_FS: begin
                if (!capture_en) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    state_nxt  = XFER;
                    load_frame = 1'b1;
                end
            end
            XFER, DRAIN: begin
                sync_err_pulse = frame_start;
                if (!capture_en) begin
                    restart_clr = 1'b1;
                    if (mem_free) state_nxt = IDLE;
                end else if (frame_start || restart_q) begin
                    if (mem_free) begin
                        load_frame  = 1'b1;
                        restart_clr = 1'b1;
                        state_nxt   = XFER;
                    end else begin
                        restart_set = 1'b1;
                    end
                end else begin
                    pop = !bus.fifo_empty && mem_free;
                    if (state == XFER && frame_end)
                        state_nxt = DRAIN;
                    else if (state == DRAIN && bus.fifo_empty && mem_free)
                        state_nxt = DONE;
                end
            end
            DONE: state_nxt = snapshot_mode ? HALT : WAIT_FS;
            HALT: if (!capture_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        pop_keep      = pop && (words_q != len_q);
        ovf_err_pulse = pop && (words_q == len_q) && !ovf_q;
    end

    always_ff @(posedge hclk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            next_addr   <= '0;
            len_q       <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
            restart_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (restart_clr)
                restart_q <= 1'b0;
            else if (restart_set)
                restart_q <= 1'b1;
            if (load_frame) begin
                next_addr <= dcmi_dma_saddr;
                len_q     <= dcmi_dma_len;
                words_q   <= '0;
                ovf_q     <= 1'b0;
            end else if (pop_keep) begin
                next_addr <= next_addr + 18'd1;
                words_q   <= words_q + 18'd1;
            end else if (pop) begin
                ovf_q     <= 1'b1;
            end
            if (pop_keep) begin
                mem_req_q   <= 1'b1;
                mem_addr_q  <= next_addr;
                mem_wdata_q <= bus.fifo_rdata;
            end else if (bus.mem_gnt) begin
                mem_req_q   <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd       = pop;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign busy              = (state != IDLE);
    assign words_written     = words_q;
    assign frame_done_pulse  = (state == DONE);

endmodule

// File: tb/tb_dcmi_dma_ctrl.sv
// Directed bench for dcmi_dma_ctrl: FIFO model, write logger and
// hand-computed expectations for each scenario.
module tb_dcmi_dma_ctrl;
    import dcmi_pkg::*;

    logic              hclk = 1'b0;
    logic              rstn = 1'b0;
    logic              capture_en = 1'b0;
    logic              snapshot_mode = 1'b0;
    logic [ADDR_W-1:0] dcmi_dma_saddr = '0;
    logic [ADDR_W-1:0] dcmi_dma_len = '0;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic              busy, frame_done_pulse, ovf_err_pulse, sync_err_pulse;
    logic [ADDR_W-1:0] words_written;

    dcmi_dma_ctrl_if bus ();

    dcmi_dma_ctrl dut (
        .hclk            (hclk),
        .rstn            (rstn),
        .capture_en      (capture_en),
        .snapshot_mode   (snapshot_mode),
        .dcmi_dma_saddr  (dcmi_dma_saddr),
        .dcmi_dma_len    (dcmi_dma_len),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .bus             (bus),
        .busy            (busy),
        .words_written   (words_written),
        .frame_done_pulse(frame_done_pulse),
        .ovf_err_pulse   (ovf_err_pulse),
        .sync_err_pulse  (sync_err_pulse)
    );

    always #5 hclk = ~hclk;

    // First-word-fall-through FIFO model: pushed from the stimulus, popped by the DUT.
    logic [31:0] fifo_mem [0:15];
    logic [4:0]  wr_ptr = '0;
    logic [4:0]  rd_ptr = '0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_rdata = fifo_mem[rd_ptr[3:0]];

    always @(posedge hclk) begin
        if (bus.fifo_rd) rd_ptr <= rd_ptr + 5'd1;
    end

    logic [17:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    int wr_cnt = 0, rd_cnt = 0, ovf_cnt = 0, done_cnt = 0, sync_cnt = 0, cyc = 0;
    int ovf_rd_idx = 0;

    // Mid-cycle monitor: logs granted writes and counts pulses.
    always @(negedge hclk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (bus.mem_req && bus.mem_gnt) begin
                wr_addr[wr_cnt] <= bus.mem_addr;
                wr_data[wr_cnt] <= bus.mem_wdata;
                wr_cyc[wr_cnt]  <= cyc;
                wr_cnt          <= wr_cnt + 1;
            end
            if (bus.fifo_rd) rd_cnt <= rd_cnt + 1;
            if (ovf_err_pulse) begin
                ovf_cnt    <= ovf_cnt + 1;
                ovf_rd_idx <= rd_cnt;
            end
            if (frame_done_pulse) done_cnt <= done_cnt + 1;
            if (sync_err_pulse) sync_cnt <= sync_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #2;
    endtask

    task automatic pushWord(input logic [31:0] d);
        fifo_mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    // One frame: frame_start, push n words from data_base upward, then frame_end.
    task automatic applyStimulus(input logic [17:0] saddr, input logic [17:0] len,
                                 input int n, input logic [31:0] data_base);
        dcmi_dma_saddr = saddr;
        dcmi_dma_len   = len;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) pushWord(data_base + 32'(i));
        step(1);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
    endtask

    task automatic waitDone(input int base, input int budget);
        for (int i = 0; i < budget && done_cnt == base; i++) step(1);
        checkOutput("frame_done_seen", 32'(done_cnt - base), 32'd1);
    endtask

    int b_wr, b_ovf, b_done, b_rd, b_sync;

    initial begin
        bus.mem_gnt = 1'b0;
        #3;
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_words", 32'(words_written), 32'd0);
        step(2);
        rstn = 1'b1;
        step(1);

        // Basic continuous frame, back-to-back writes
        capture_en = 1'b1;
        bus.mem_gnt = 1'b1;
        step(1);
        checkOutput("enter_wait_fs", 32'(dut.state), 32'(WAIT_FS));
        b_wr = wr_cnt; b_done = done_cnt;
        applyStimulus(18'h100, 18'd4, 4, 32'hA000_0000);
        waitDone(b_done, 40);
        checkOutput("t1_writes", 32'(wr_cnt - b_wr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_addr", 32'(wr_addr[b_wr + i]), 32'h100 + 32'(i));
            checkOutput("t1_data", wr_data[b_wr + i], 32'hA000_0000 + 32'(i));
        end
        checkOutput("t1_b2b", 32'(wr_cyc[b_wr + 3] - wr_cyc[b_wr]), 32'd3);
        checkOutput("t1_state", 32'(dut.state), 32'(WAIT_FS));
        checkOutput("t1_words", 32'(words_written), 32'd4);

        // Overflow: len 2, three words
        b_wr = wr_cnt; b_done = done_cnt; b_ovf = ovf_cnt; b_rd = rd_cnt;
        applyStimulus(18'h200, 18'd2, 3, 32'hB000_0000);
        waitDone(b_done, 40);
        checkOutput("t2_writes", 32'(wr_cnt - b_wr), 32'd2);
        checkOutput("t2_ovf_cnt", 32'(ovf_cnt - b_ovf), 32'd1);
        checkOutput("t2_ovf_on_3rd_pop", 32'(ovf_rd_idx - b_rd), 32'd2);
        checkOutput("t2_fifo_empty", 32'(bus.fifo_empty), 32'd1);
        checkOutput("t2_words", 32'(words_written), 32'd2);

        // Grant stall: request held stable for 5 cycles with no further pops
        bus.mem_gnt = 1'b0;
        b_wr = wr_cnt; b_done = done_cnt;
        dcmi_dma_saddr = 18'h300;
        dcmi_dma_len   = 18'd4;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        pushWord(32'hC000_0001);
        pushWord(32'hC000_0002);
        step(1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_req_held", 32'(bus.mem_req), 32'd1);
            checkOutput("t3_addr_held", 32'(bus.mem_addr), 32'h300);
            checkOutput("t3_data_held", bus.mem_wdata, 32'hC000_0001);
            checkOutput("t3_no_pop", 32'(bus.fifo_rd), 32'd0);
            step(1);
        end
        bus.mem_gnt = 1'b1;
        step(1);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        waitDone(b_done, 40);
        checkOutput("t3_writes", 32'(wr_cnt - b_wr), 32'd2);
        checkOutput("t3_addr1", 32'(wr_addr[b_wr + 1]), 32'h301);

        // Address wrap at the top of the 18-bit space
        b_wr = wr_cnt; b_done = done_cnt;
        applyStimulus(18'h3FFFE, 18'd4, 4, 32'hD000_0000);
        waitDone(b_done, 40);
        checkOutput("t4_wrap_a0", 32'(wr_addr[b_wr]), 32'h3FFFE);
        checkOutput("t4_wrap_a1", 32'(wr_addr[b_wr + 1]), 32'h3FFFF);
        checkOutput("t4_wrap_a2", 32'(wr_addr[b_wr + 2]), 32'h00000);
        checkOutput("t4_wrap_a3", 32'(wr_addr[b_wr + 3]), 32'h00001);

        // Zero-length buffer: every word discarded, single overflow pulse
        b_wr = wr_cnt; b_done = done_cnt; b_ovf = ovf_cnt;
        applyStimulus(18'h10, 18'd0, 2, 32'hE000_0000);
        waitDone(b_done, 40);
        checkOutput("t5_writes", 32'(wr_cnt - b_wr), 32'd0);
        checkOutput("t5_ovf_cnt", 32'(ovf_cnt - b_ovf), 32'd1);

        // Sync error: frame_start mid-transfer restarts at saddr
        b_wr = wr_cnt; b_done = done_cnt; b_sync = sync_cnt;
        dcmi_dma_saddr = 18'h400;
        dcmi_dma_len   = 18'd8;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        pushWord(32'hF000_0000);
        pushWord(32'hF000_0001);
        step(4);
        checkOutput("t6_words_before", 32'(words_written), 32'd2);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        checkOutput("t6_sync_cnt", 32'(sync_cnt - b_sync), 32'd1);
        checkOutput("t6_state", 32'(dut.state), 32'(XFER));
        checkOutput("t6_words_clear", 32'(words_written), 32'd0);
        pushWord(32'h0000_BEEF);
        step(1);
        frame_end = 1'b1;
        step(1);
        frame_end = 1'b0;
        waitDone(b_done, 40);
        checkOutput("t6_writes", 32'(wr_cnt - b_wr), 32'd3);
        checkOutput("t6_restart_addr", 32'(wr_addr[b_wr + 2]), 32'h400);
        checkOutput("t6_restart_data", wr_data[b_wr + 2], 32'h0000_BEEF);

        // Snapshot: halt after one frame, ignore later frames
        snapshot_mode = 1'b1;
        b_done = done_cnt;
        applyStimulus(18'h50, 18'd2, 1, 32'h1234_5678);
        waitDone(b_done, 40);
        checkOutput("t7_halt", 32'(dut.state), 32'(HALT));
        b_wr = wr_cnt; b_rd = rd_cnt;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        pushWord(32'h5555_5555);
        step(4);
        checkOutput("t7_no_writes", 32'(wr_cnt - b_wr), 32'd0);
        checkOutput("t7_no_pops", 32'(rd_cnt - b_rd), 32'd0);
        capture_en = 1'b0;
        step(1);
        checkOutput("t7_idle", 32'(dut.state), 32'(IDLE));
        checkOutput("t7_busy", 32'(busy), 32'd0);
        wr_ptr = rd_ptr;
        snapshot_mode = 1'b0;

        // Asynchronous reset while a write is pending
        bus.mem_gnt = 1'b0;
        capture_en = 1'b1;
        step(1);
        dcmi_dma_saddr = 18'h77;
        dcmi_dma_len   = 18'd4;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        pushWord(32'h9999_0000);
        step(1);
        checkOutput("t8_req_pending", 32'(bus.mem_req), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("t8_rst_req", 32'(bus.mem_req), 32'd0);
        checkOutput("t8_rst_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("t8_rst_wdata", bus.mem_wdata, 32'd0);
        checkOutput("t8_rst_busy", 32'(busy), 32'd0);
        checkOutput("t8_rst_words", 32'(words_written), 32'd0);
        checkOutput("t8_rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        capture_en = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
        checkOutput("t8_after_rst", 32'(dut.state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
